// File: rtl/psec5_spi_ctrl_readout_if.sv
// SPI pin bundle between the external master and the PSEC5 control block.
`timescale 1ns/1ps
interface psec5_spi_ctrl_readout_if;
  logic cs_n;
  logic serial_in;
  logic serial_out;

  modport master (
    output cs_n,
    output serial_in,
    input  serial_out
  );

  modport slave (
    input  cs_n,
    input  serial_in,
    output serial_out
  );
endinterface

// File: rtl/psec5_spi_ctrl_readout.sv
// PSEC5 SPI slave: configuration registers, instruction pulses and the
// per-channel CNT_SER readout multiplexer onto serial_out.
`timescale 1ns/1ps
module psec5_spi_ctrl_readout #(
  parameter int unsigned NCH          = 8,
  parameter int unsigned BYTES_PER_CH = 7,
  parameter logic [7:0]  RO_BASE      = 8'h04
) (
  input  logic                  sclk,
  input  logic                  rstn,
  psec5_spi_ctrl_readout_if.slave spi,
  input  logic [7:0]            pll_locked,
  input  logic [NCH-1:0]        raw_serial_out,
  output logic                  inst_rst,
  output logic                  inst_start,
  output logic                  inst_readout,
  output logic [NCH-1:0]        load_cnt_ser,
  output logic [NCH-1:0]        mux_control_signal,
  output logic [7:0]            mode,
  output logic [7:0]            trigger_channel_mask,
  output logic [7:0]            disc_polarity,
  output logic [7:0]            vco_control,
  output logic [7:0]            pll_div_ratio,
  output logic [7:0]            slow_mode,
  output logic [4:0]            trig_delay,
  output logic [2:0]            select_reg
);

  localparam int unsigned    RO_I    = {24'd0, RO_BASE};
  localparam logic [NCH-1:0] LSB_ONE = {{(NCH-1){1'b0}}, 1'b1};

  typedef enum logic {PH_ADDR, PH_DATA} phase_t;

  phase_t     phase;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] addr;
  logic [6:0] tx_sh;
  logic [7:0] byte_in;
  logic [7:0] next_addr;
  logic [7:0] rd_data;
  logic       byte_done;
  logic       wr_en;
  logic       frame_clr_n;

  // One-hot channel owning address a, or zero outside the readout window.
  function automatic logic [NCH-1:0] win_sel(input logic [7:0] a);
    int unsigned ai;
    ai = {24'd0, a};
    win_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ai >= RO_I + BYTES_PER_CH * i && ai < RO_I + BYTES_PER_CH * (i + 1))
        win_sel = win_sel | (LSB_ONE << i);
    end
  endfunction

  // One-hot channel whose window begins exactly at address a.
  function automatic logic [NCH-1:0] win_first(input logic [7:0] a);
    int unsigned ai;
    ai = {24'd0, a};
    win_first = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ai == RO_I + BYTES_PER_CH * i)
        win_first = win_first | (LSB_ONE << i);
    end
  endfunction

  // Frame state is wiped both by chip reset and by deselecting the chip.
  assign frame_clr_n = rstn & ~spi.cs_n;
  assign byte_in     = {shreg, spi.serial_in};
  assign byte_done   = (bit_cnt == 3'd7);
  assign wr_en       = byte_done && (phase == PH_DATA);
  assign next_addr   = (phase == PH_ADDR) ? byte_in : addr + 8'd1;

  // Readback value of the current address (window addresses stream instead).
  always_comb begin
    rd_data = '0;
    case (addr)
      8'h00:   rd_data = pll_locked;
      8'h02:   rd_data = mode;
      8'h03:   rd_data = trigger_channel_mask;
      8'h3C:   rd_data = disc_polarity;
      8'h3D:   rd_data = vco_control;
      8'h3E:   rd_data = pll_div_ratio;
      8'h3F:   rd_data = slow_mode;
      8'h40:   rd_data = {3'b000, trig_delay};
      8'h41:   rd_data = {5'b00000, select_reg};
      default: rd_data = '0;
    endcase
  end

  // Frame FSM: bit capture, address tracking, instruction and load pulses.
  always_ff @(posedge sclk or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      phase              <= PH_ADDR;
      bit_cnt            <= '0;
      shreg              <= '0;
      addr               <= '0;
      inst_rst           <= 1'b0;
      inst_start         <= 1'b0;
      inst_readout       <= 1'b0;
      load_cnt_ser       <= '0;
      mux_control_signal <= '0;
    end else begin
      bit_cnt      <= bit_cnt + 3'd1;
      shreg        <= byte_in[6:0];
      inst_rst     <= 1'b0;
      inst_start   <= 1'b0;
      inst_readout <= 1'b0;
      load_cnt_ser <= '0;
      if (byte_done) begin
        phase              <= PH_DATA;
        addr               <= next_addr;
        mux_control_signal <= win_sel(next_addr);
        load_cnt_ser       <= win_first(next_addr);
        if (phase == PH_DATA && addr == 8'h01) begin
          inst_rst     <= byte_in[0];
          inst_start   <= byte_in[1];
          inst_readout <= byte_in[2];
        end
      end
    end
  end

  // Configuration registers survive deselect; only chip reset clears them.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      mode                 <= '0;
      trigger_channel_mask <= '0;
      disc_polarity        <= '0;
      vco_control          <= '0;
      pll_div_ratio        <= '0;
      slow_mode            <= '0;
      trig_delay           <= '0;
      select_reg           <= '0;
    end else if (wr_en) begin
      case (addr)
        8'h02:   mode                 <= byte_in;
        8'h03:   trigger_channel_mask <= byte_in;
        8'h3C:   disc_polarity        <= byte_in;
        8'h3D:   vco_control          <= byte_in;
        8'h3E:   pll_div_ratio        <= byte_in;
        8'h3F:   slow_mode            <= byte_in;
        8'h40:   trig_delay           <= byte_in[4:0];
        8'h41:   select_reg           <= byte_in[2:0];
        default: ;
      endcase
    end
  end

  // MISO driver: stream the selected channel, else shift out the readback
  // byte latched on the falling edge that ends the previous byte.
  always_ff @(negedge sclk or negedge frame_clr_n) begin
    if (!frame_clr_n) begin
      spi.serial_out <= 1'b0;
      tx_sh          <= '0;
    end else if (|mux_control_signal) begin
      spi.serial_out <= |(raw_serial_out & mux_control_signal);
    end else if (phase == PH_DATA && bit_cnt == 3'd0) begin
      spi.serial_out <= rd_data[7];
      tx_sh          <= rd_data[6:0];
    end else begin
      spi.serial_out <= tx_sh[6];
      tx_sh          <= {tx_sh[5:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_psec5_spi_ctrl_readout.sv
// Randomized self-checking bench for psec5_spi_ctrl_readout against a
// frame-level reference model of the register map and readout window.
`timescale 1ns/1ps
module tb_psec5_spi_ctrl_readout;
  localparam int unsigned NCH = 8;

  logic           sclk;
  logic           rstn;
  logic [7:0]     pll_locked;
  logic [NCH-1:0] raw_serial_out;
  logic           inst_rst, inst_start, inst_readout;
  logic [NCH-1:0] load_cnt_ser, mux_control_signal;
  logic [7:0]     mode, trigger_channel_mask, disc_polarity, vco_control, pll_div_ratio, slow_mode;
  logic [4:0]     trig_delay;
  logic [2:0]     select_reg;

  psec5_spi_ctrl_readout_if spi ();

  psec5_spi_ctrl_readout #(
    .NCH(NCH),
    .BYTES_PER_CH(7),
    .RO_BASE(8'h04)
  ) dut (
    .sclk(sclk),
    .rstn(rstn),
    .spi(spi.slave),
    .pll_locked(pll_locked),
    .raw_serial_out(raw_serial_out),
    .inst_rst(inst_rst),
    .inst_start(inst_start),
    .inst_readout(inst_readout),
    .load_cnt_ser(load_cnt_ser),
    .mux_control_signal(mux_control_signal),
    .mode(mode),
    .trigger_channel_mask(trigger_channel_mask),
    .disc_polarity(disc_polarity),
    .vco_control(vco_control),
    .pll_div_ratio(pll_div_ratio),
    .slow_mode(slow_mode),
    .trig_delay(trig_delay),
    .select_reg(select_reg)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mode, m_mask, m_disc, m_vco, m_pll, m_slow;
  logic [4:0] m_td;
  logic [2:0] m_sel;

  task automatic m_reset();
    m_mode = 0; m_mask = 0; m_disc = 0; m_vco = 0;
    m_pll = 0; m_slow = 0; m_td = 0; m_sel = 0;
  endtask

  // Channel owning a readout address, -1 outside the window.
  function automatic int win_ch(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai >= 4 && ai <= 59) return (ai - 4) / 7;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return pll_locked;
      8'h02: return m_mode;
      8'h03: return m_mask;
      8'h3C: return m_disc;
      8'h3D: return m_vco;
      8'h3E: return m_pll;
      8'h3F: return m_slow;
      8'h40: return {3'b000, m_td};
      8'h41: return {5'b00000, m_sel};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h02: m_mode = d;
      8'h03: m_mask = d;
      8'h3C: m_disc = d;
      8'h3D: m_vco  = d;
      8'h3E: m_pll  = d;
      8'h3F: m_slow = d;
      8'h40: m_td   = d[4:0];
      8'h41: m_sel  = d[2:0];
      default: ;
    endcase
  endtask

  // ---------------- SPI master ----------------
  logic [7:0]  fb [64];
  logic [7:0]  rx [64];
  logic [18:0] hs [64];
  int          fn;

  function automatic logic [18:0] snap();
    return {inst_readout, inst_start, inst_rst, load_cnt_ser, mux_control_signal};
  endfunction

  task automatic xfer_bit(input logic b, output logic miso, output logic [NCH-1:0] rlo,
                          output logic [18:0] slo, output logic [18:0] shi);
    spi.serial_in = b;
    #5;
    miso = spi.serial_out;
    rlo  = raw_serial_out;
    slo  = snap();
    #5 sclk = 1'b1;
    #5;
    shi = snap();
    raw_serial_out = 8'($urandom);
    #5 sclk = 1'b0;
  endtask

  task automatic check_cfg();
    check("cfg_mode", mode, m_mode);
    check("cfg_mask", trigger_channel_mask, m_mask);
    check("cfg_disc", disc_polarity, m_disc);
    check("cfg_vco", vco_control, m_vco);
    check("cfg_pll", pll_div_ratio, m_pll);
    check("cfg_slow", slow_mode, m_slow);
    check("cfg_tdly", trig_delay, m_td);
    check("cfg_sel", select_reg, m_sel);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_miso"}, spi.serial_out, 0);
    check({tag, "_inst"}, {inst_readout, inst_start, inst_rst}, 0);
    check({tag, "_load"}, load_cnt_ser, 0);
    check({tag, "_mux"}, mux_control_signal, 0);
    check_cfg();
  endtask

  task automatic do_frame();
    logic [7:0]     addr, exp_b, got_b, rdv, e_load, e_mux;
    logic [2:0]     e_inst;
    logic           mb;
    logic [NCH-1:0] rl;
    logic [18:0]    slo, shi, hi8;
    int             ch;
    spi.cs_n = 1'b0;
    #10;
    addr = 0; e_inst = 0; e_load = 0; e_mux = 0; hi8 = 0;
    for (int k = 0; k < fn; k++) begin
      ch  = (k == 0) ? -1 : win_ch(addr);
      rdv = (k == 0) ? 8'h00 : m_read(addr);
      for (int j = 7; j >= 0; j--) begin
        xfer_bit(fb[k][j], mb, rl, slo, shi);
        got_b[j] = mb;
        exp_b[j] = (ch >= 0) ? rl[ch] : rdv[j];
        if (j == 7) begin
          check("inst_hold", slo[18:16], e_inst);
          check("load_hold", slo[15:8], e_load);
          check("inst_end", shi[18:16], 0);
          check("load_end", shi[15:8], 0);
          check("mux_hold", shi[7:0], e_mux);
        end
        if (j == 0) hi8 = shi;
      end
      rx[k] = got_b;
      hs[k] = hi8;
      check("miso", got_b, exp_b);
      if (k == 0) begin
        addr   = fb[k];
        e_inst = 0;
      end else begin
        e_inst = (addr == 8'h01) ? fb[k][2:0] : 3'b000;
        m_write(addr, fb[k]);
        addr = addr + 8'd1;
      end
      ch     = win_ch(addr);
      e_mux  = (ch >= 0) ? (8'd1 << ch) : 8'd0;
      e_load = (ch >= 0 && ((int'(addr) - 4) % 7) == 0) ? e_mux : 8'd0;
      check("inst", hi8[18:16], e_inst);
      check("load", hi8[15:8], e_load);
      check("mux", hi8[7:0], e_mux);
    end
    #10 spi.cs_n = 1'b1;
    #1;
    check("idle_inst", {inst_readout, inst_start, inst_rst}, 0);
    check("idle_load", load_cnt_ser, 0);
    check("idle_mux", mux_control_signal, 0);
    check("idle_miso", spi.serial_out, 0);
    #20;
    check_cfg();
  endtask

  logic [7:0] pick [12];
  logic           d_mb;
  logic [NCH-1:0] d_rl;
  logic [18:0]    d_slo, d_shi;

  initial begin
    pick = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h3C, 8'h3D, 8'h3E, 8'h3F,
             8'h40, 8'h41, 8'hFE, 8'h35};
    sclk = 1'b0; rstn = 1'b0;
    spi.cs_n = 1'b1; spi.serial_in = 1'b0;
    pll_locked = 8'h81; raw_serial_out = '0;
    m_reset();
    #10;
    check_zero("por");
    #20 rstn = 1'b1;
    #20;

    // Write then read back mode.
    fb[0] = 8'h02; fb[1] = 8'h03; fn = 2; do_frame();
    check("mode_wr", mode, 8'h03);
    fb[0] = 8'h02; fb[1] = 8'h02; fn = 2; do_frame();
    check("mode_rb", rx[1], 8'h03);
    check("mode_wr2", mode, 8'h02);

    // Instruction pulses; third byte lands on mode.
    fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h02; fn = 3; do_frame();
    check("inst_pulse", hs[1][18:16], 3'b011);
    check("inst_rd", rx[1], 8'h00);

    // Burst with auto-increment.
    fb[0] = 8'h3C; fb[1] = 8'hA5; fb[2] = 8'h5A; fb[3] = 8'h0F; fn = 4; do_frame();
    check("burst_disc", disc_polarity, 8'hA5);
    check("burst_vco", vco_control, 8'h5A);
    check("burst_pll", pll_div_ratio, 8'h0F);

    // Status and address wrap.
    pll_locked = 8'h81;
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00; fn = 3; do_frame();
    check("wrap_ff", rx[1], 8'h00);
    check("wrap_00", rx[2], 8'h81);

    // Full readout window sweep.
    fb[0] = 8'h04;
    for (int k = 1; k <= 56; k++) fb[k] = 8'($urandom);
    fn = 57; do_frame();
    for (int i = 0; i < 8; i++) check("load_seq", hs[7 * i][15:8], 8'd1 << i);
    check("win_exit", hs[56][7:0], 8'h00);

    // Partial data byte is discarded.
    spi.cs_n = 1'b0; #10;
    for (int j = 7; j >= 0; j--) xfer_bit(1'(8'h02 >> j), d_mb, d_rl, d_slo, d_shi);
    for (int j = 0; j < 5; j++) xfer_bit(1'b1, d_mb, d_rl, d_slo, d_shi);
    #10 spi.cs_n = 1'b1; #20;
    check("partial_mode", mode, m_mode);

    // Reset in the middle of a frame.
    spi.cs_n = 1'b0; #10;
    for (int j = 0; j < 11; j++) xfer_bit(1'($urandom), d_mb, d_rl, d_slo, d_shi);
    rstn = 1'b0; #3;
    m_reset();
    check_zero("midrst");
    #10 rstn = 1'b1;
    #5 spi.cs_n = 1'b1; #20;
    fb[0] = 8'h02; fb[1] = 8'h77; fn = 2; do_frame();
    check("post_rst_rb", rx[1], 8'h00);
    check("post_rst_mode", mode, 8'h77);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      pll_locked = 8'($urandom);
      fb[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 11)];
      fn = $urandom_range(1, 6);
      for (int k = 1; k < fn; k++) fb[k] = 8'($urandom);
      do_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psec5_spi_ctrl_readout.md
Name: psec5_spi_ctrl_readout

Overview:
- SPI slave configuration and readout block for the PSEC5 8-channel digitizer.
- Holds the chip configuration registers and issues instruction pulses to the channel digitals.
- Multiplexes serial data onto one serial_out pin: either register readback or the serialized counter stream (CNT_SER) of one selected channel.
- Sits between the external SPI master and the eight per-channel digital blocks.

Parameters:
- NCH, 8, number of channels (raw_serial_out, load_cnt_ser, mux_control_signal widths).
- BYTES_PER_CH, 7, readout bytes per channel window.
- RO_BASE, 8'h04, first address of the channel readout window.

Ports:
- sclk  in  1  SPI clock, the only clock. Capture on rising edge, drive on falling edge.
- rstn  in  1  asynchronous active-low reset.
- cs_n  in  1  frame select, active low. High asynchronously clears frame state.
- serial_in  in  1  MOSI, MSB first.
- pll_locked  in  8  status bits, readable at 0x00.
- raw_serial_out  in  NCH  CNT_SER bit streams from channels 0..7.
- serial_out  out  1  MISO.
- inst_rst, inst_start, inst_readout  out  1 each  instruction pulses.
- load_cnt_ser  out  NCH  one-hot load strobe to the channel serializers.
- mux_control_signal  out  NCH  one-hot selected readout channel; 0 = register readback.
- mode, trigger_channel_mask, disc_polarity, vco_control, pll_div_ratio, slow_mode  out  8 each  configuration registers.
- trig_delay  out  5  configuration.
- select_reg  out  3  configuration.

Behaviour:
- Frame structure:
  - Frame starts at cs_n falling.
  - Byte 0 = address A.
  - Each later byte is a data byte at the current address.
  - Address post-increments after each data byte; 8-bit wrap 0xFF->0x00.
- Bit capture:
  - Bits are shifted in on sclk rising edge, MSB first.
  - A byte completes on its 8th rising edge.
- Address map (R/W unless noted):
  - 0x00 pll_locked, RO.
  - 0x01 instruction, W-only, reads 0.
  - 0x02 mode.
  - 0x03 trigger_channel_mask.
  - 0x04..0x3B channel readout window, RO.
  - 0x3C disc_polarity.
  - 0x3D vco_control.
  - 0x3E pll_div_ratio.
  - 0x3F slow_mode.
  - 0x40 trig_delay[4:0].
  - 0x41 select_reg[2:0].
  - Unmapped: reads 0x00, writes ignored. Writes to RO addresses are ignored.
- Register writes take effect on the 8th rising edge of the data byte.
- Instruction write (0x01):
  - Bit0 -> inst_rst, bit1 -> inst_start, bit2 -> inst_readout.
  - Each set bit pulses high for exactly one sclk period, from that 8th rising edge to the next rising edge.
  - Pulses self-clear even if sclk then stops (cleared by the next edge, or by cs_n high, or by rstn).
- Readback (full duplex):
  - During each data byte, serial_out returns the pre-write value of the current address.
  - The MSB is driven on the falling edge that ends the previous byte; following bits are driven on subsequent falling edges.
  - During the address byte serial_out = 0.
- Readout window, for current address A in 0x04..0x3B:
  - ch = (A-4) div 7.
  - mux_control_signal = 1<<ch.
  - serial_out = raw_serial_out[ch], re-registered on every falling edge (streaming, not byte-latched).
  - load_cnt_ser[ch] is high for one sclk period starting at the rising edge that completes the byte which makes A = 4+7*ch. This is the last byte before the window, so channels serialize starting with the first window byte.
  - Outside the window, mux_control_signal = 0.
- Reset (rstn low, asynchronous): all registers, outputs, pulses, bit/byte counters, address and serial_out go to 0.
- cs_n high clears only frame state: bit counter, byte index, mux selection and pulses. Configuration registers are kept.
- A partial byte (fewer than 8 bits) at cs_n rise is discarded, with no write.

Test Plan:
- Reset: rstn low mid-frame -> every output 0; next frame decodes byte 0 as an address.
- Write/readback: frame {0x02, 0x03}, then frame {0x02, 0x02} -> mode = 0x03 after the first frame; second frame returns 0x03 on MISO; mode = 0x02 afterwards.
- Instruction: frame {0x01, 0x03} -> inst_rst and inst_start high for exactly one sclk period, inst_readout stays 0; reading 0x01 returns 0x00.
- Burst with auto-increment: frame {0x3C, 0xA5, 0x5A, 0x0F} -> disc_polarity = 0xA5, vco_control = 0x5A, pll_div_ratio = 0x0F.
- Readout: frame {0x04} followed by 56 bytes, with raw_serial_out driven by counter models -> load_cnt_ser pulses 0x01, 0x02, ... 0x80 at each 7-byte boundary; mux_control_signal one-hot tracks the channel; MISO equals the selected channel stream bit for bit.
- Status and wrap: pll_locked = 0x81, frame {0xFF, 0x00, 0x00} -> first data byte reads 0x00 (unmapped 0xFF), second data byte reads 0x81 at address 0x00.
